// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header size and packet-parser state encoding for the UART ALU core.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;

  localparam int HDR_BYTES = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RSVD,
    ST_LEN_L,
    ST_LEN_H,
    ST_ECHO,
    ST_OPERAND,
    ST_MUL_BUSY,
    ST_SEND,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/uart_alu_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, OPERAND_W cycles from start
// to the done pulse, low OPERAND_W bits of the product.
module uart_alu_mul #(
  parameter int OPERAND_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic                 done,
  output logic [OPERAND_W-1:0] product
);

  localparam int CNT_W = $clog2(OPERAND_W + 1);

  logic [OPERAND_W-1:0] a_reg;
  logic [OPERAND_W-1:0] b_reg;
  logic [OPERAND_W-1:0] acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 run_reg;
  logic                 done_reg;

  // Bit 0 is folded in on the start edge, so done is visible exactly OPERAND_W cycles later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        acc_reg  <= b[0] ? a : '0;
        a_reg    <= a << 1;
        b_reg    <= b >> 1;
        cnt_reg  <= CNT_W'(OPERAND_W - 1);
        run_reg  <= (OPERAND_W > 1);
        done_reg <= (OPERAND_W == 1);
      end else if (run_reg) begin
        if (b_reg[0]) begin
          acc_reg <= acc_reg + a_reg;
        end
        a_reg   <= a_reg << 1;
        b_reg   <= b_reg >> 1;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/uart_alu_core.sv
// Command packet processor between uart_rx and uart_tx: parses [op, rsvd, len_l, len_h, payload]
// and returns echoed payload or a little-endian ADD/MUL result.
module uart_alu_core
  import uart_alu_pkg::*;
#(
  parameter int OPERAND_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy,
  output logic       err_o
);

  localparam int BYTES = OPERAND_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t               state_reg, state_next;
  logic [7:0]           opcode_reg, opcode_next;
  logic [7:0]           len_l_reg, len_l_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 first_reg, first_next;
  logic [OPERAND_W-1:0] operand_reg, operand_next;
  logic [OPERAND_W-1:0] acc_reg, acc_next;
  logic [7:0]           m_tdata_reg, m_tdata_next;
  logic                 m_tvalid_reg, m_tvalid_next;
  logic                 err_reg, err_next;

  logic                 in_fire;
  logic                 out_fire;
  logic [15:0]          len_w;
  logic [15:0]          payload;
  logic [OPERAND_W-1:0] opnd_full;
  logic                 last_opnd_byte;
  logic [IDX_W-1:0]     idx_inc;
  logic                 mul_start;
  logic                 mul_done;
  logic [OPERAND_W-1:0] mul_product;
  logic [7:0]           acc_bytes [BYTES];

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_acc_bytes
    assign acc_bytes[gi] = acc_reg[8*gi +: 8];
  end

  assign in_fire        = s_axis_tvalid && s_axis_tready;
  assign out_fire       = m_tvalid_reg && m_axis_tready;
  assign len_w          = {s_axis_tdata, len_l_reg};
  assign payload        = (len_w < 16'(HDR_BYTES)) ? 16'd0 : len_w - 16'(HDR_BYTES);
  assign opnd_full      = OPERAND_W'({s_axis_tdata, operand_reg} >> 8);
  assign last_opnd_byte = (idx_reg == IDX_W'(BYTES - 1));
  assign idx_inc        = idx_reg + 1'b1;

  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign err_o         = err_reg;
  assign busy          = (state_reg != ST_IDLE);

  // ECHO stops accepting once its payload is in, so the next opcode is not swallowed while draining.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_reg)
      ST_IDLE, ST_RSVD, ST_LEN_L, ST_LEN_H, ST_OPERAND, ST_DRAIN: s_axis_tready = 1'b1;
      ST_ECHO: s_axis_tready = (cnt_reg != 16'd0) && (!m_tvalid_reg || m_axis_tready);
      default: s_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    opcode_next   = opcode_reg;
    len_l_next    = len_l_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    first_next    = first_reg;
    operand_next  = operand_reg;
    acc_next      = acc_reg;
    m_tdata_next  = m_tdata_reg;
    m_tvalid_next = m_tvalid_reg;
    err_next      = 1'b0;
    mul_start     = 1'b0;
    case (state_reg)
      ST_IDLE: if (in_fire) begin
        opcode_next = s_axis_tdata;
        state_next  = ST_RSVD;
      end
      ST_RSVD: if (in_fire) state_next = ST_LEN_L;
      ST_LEN_L: if (in_fire) begin
        len_l_next = s_axis_tdata;
        state_next = ST_LEN_H;
      end
      ST_LEN_H: if (in_fire) begin
        cnt_next   = payload;
        idx_next   = '0;
        first_next = 1'b1;
        if (opcode_reg == OP_ECHO) begin
          state_next = (payload == 16'd0) ? ST_IDLE : ST_ECHO;
        end else if ((opcode_reg == OP_ADD || opcode_reg == OP_MUL) &&
                     payload >= 16'(BYTES) && (payload % 16'(BYTES)) == 16'd0) begin
          state_next = ST_OPERAND;
        end else begin
          err_next   = 1'b1;
          state_next = (payload == 16'd0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_ECHO: begin
        if (out_fire) m_tvalid_next = 1'b0;
        if (in_fire) begin
          m_tdata_next  = s_axis_tdata;
          m_tvalid_next = 1'b1;
          cnt_next      = cnt_reg - 1'b1;
        end
        if (cnt_reg == 16'd0 && (!m_tvalid_reg || m_axis_tready)) state_next = ST_IDLE;
      end
      ST_OPERAND: if (in_fire) begin
        cnt_next     = cnt_reg - 1'b1;
        operand_next = opnd_full;
        if (last_opnd_byte) begin
          idx_next   = '0;
          first_next = 1'b0;
          if (first_reg) acc_next = opnd_full;
          else if (opcode_reg == OP_ADD) acc_next = acc_reg + opnd_full;
          if (!first_reg && opcode_reg == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_MUL_BUSY;
          end else if (cnt_reg == 16'd1) begin
            m_tdata_next  = acc_next[7:0];
            m_tvalid_next = 1'b1;
            state_next    = ST_SEND;
          end
        end else begin
          idx_next = idx_inc;
        end
      end
      ST_MUL_BUSY: if (mul_done) begin
        acc_next = mul_product;
        if (cnt_reg == 16'd0) begin
          m_tdata_next  = mul_product[7:0];
          m_tvalid_next = 1'b1;
          state_next    = ST_SEND;
        end else begin
          state_next = ST_OPERAND;
        end
      end
      ST_SEND: if (out_fire) begin
        if (last_opnd_byte) begin
          m_tvalid_next = 1'b0;
          idx_next      = '0;
          state_next    = ST_IDLE;
        end else begin
          idx_next     = idx_inc;
          m_tdata_next = acc_bytes[idx_inc];
        end
      end
      ST_DRAIN: if (in_fire) begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == 16'd1) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      opcode_reg   <= '0;
      len_l_reg    <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      first_reg    <= 1'b0;
      operand_reg  <= '0;
      acc_reg      <= '0;
      m_tdata_reg  <= '0;
      m_tvalid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      len_l_reg    <= len_l_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      first_reg    <= first_next;
      operand_reg  <= operand_next;
      acc_reg      <= acc_next;
      m_tdata_reg  <= m_tdata_next;
      m_tvalid_reg <= m_tvalid_next;
      err_reg      <= err_next;
    end
  end

  uart_alu_mul #(
    .OPERAND_W(OPERAND_W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (acc_reg),
    .b      (opnd_full),
    .done   (mul_done),
    .product(mul_product)
  );

endmodule
